comp2_result_fifo: RTL and testbench
====================================

Name: comp2_result_fifo

Overview:
- Parametrised successor to the multiplier's two's-complement result stage.
- Captures unsigned magnitude results from the sequential multiplier on its stop strobe, applies the sign (two's-complement or sign-magnitude format) and range-checks against a configurable output width.
- Queues results in a DEPTH-entry FIFO drained by a valid/ready handshake.
- Sits between the multiplier datapath and the downstream consumer, so back-to-back products are not lost while the consumer stalls.

Parameters:
- IN_W, 16, width of the unsigned magnitude input.
- OUT_W, 16, width of the formatted output; may be narrower or wider than IN_W.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- MODE, 0, output format: 0 = two's complement, 1 = sign-magnitude (MSB = sign, OUT_W-1 magnitude bits).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-low reset.
- i_val  in  IN_W  unsigned product magnitude.
- i_signA  in  1  sign of operand A.
- i_signB  in  1  sign of operand B.
- i_stop  in  1  one-cycle strobe: i_val and the signs are final; push a result.
- i_start  in  1  new operation started; clears sticky o_drop.
- i_clear  in  1  synchronous FIFO flush.
- i_ready  in  1  consumer accepts the head entry.
- o_product  out  OUT_W  formatted result at the FIFO head.
- o_sign  out  1  sign of the head result.
- o_ovf  out  1  head result did not fit in OUT_W.
- o_valid  out  1  FIFO not empty.
- o_count  out  $clog2(DEPTH+1)  current occupancy.
- o_full  out  1  occupancy == DEPTH.
- o_drop  out  1  sticky: a push was lost because the FIFO was full.

Behaviour:
- Interface: one clock i_clk; reset i_rst is asynchronous and active-low.
- Reset state: all outputs 0, FIFO empty, read/write pointers 0, o_drop 0. Assertion mid-operation discards all entries immediately, with no wait for a clock.
- Sign: neg = i_signA ^ i_signB.
- Negative-zero suppression: if i_val == 0, neg is forced to 0. Result 0, o_sign 0.
- MODE 0 range: representable when mag <= 2^(OUT_W-1)-1 (neg=0) or mag <= 2^(OUT_W-1) (neg=1).
  - In range: result = neg ? -mag : mag, sign-extended to OUT_W.
- MODE 1 range: representable when mag <= 2^(OUT_W-1)-1.
  - In range: result = {neg, mag zero-extended to OUT_W-1 bits}.
- Out of range: ovf = 1; value per the optional feature. ovf is stored per entry and presented as o_ovf with its entry.
- Push: i_stop && (!o_full || pop).
- Pop: o_valid && i_ready.
- Push/pop timing:
  - Both take effect on the same rising edge.
  - Full + push + pop: accepted; count unchanged.
  - Empty + push + i_ready: no pop that cycle; there is no bypass.
- Latency: result pushed at edge t appears at the head (o_valid=1) after edge t, i.e. in cycle t+1, if the FIFO was empty. Otherwise it appears behind older entries, in strict order.
- Head outputs: o_product, o_sign and o_ovf reflect the head entry (show-ahead). They hold stable while o_valid && !i_ready. When o_valid=0 they are 0.
- Drop: i_stop while full and no pop leaves FIFO contents unchanged and sets o_drop=1.
  - o_drop clears on i_start or i_clear.
  - If i_start and a drop occur in the same cycle, the drop wins (o_drop=1).
- i_clear: on the next edge, count=0, pointers=0, o_drop=0. It overrides a simultaneous push or pop; that cycle's i_stop is discarded.
- Pointers: wrap modulo DEPTH.
- o_count and o_full are registered-consistent: o_full == (o_count == DEPTH) in every cycle.
- Inputs i_val and the signs are sampled only on cycles where i_stop=1.

Optional Feature:
- Macro: COMP2_RESULT_SAT_EN.
- Defined: out-of-range results clamp.
  - MODE 0: to 2^(OUT_W-1)-1 for positive, -2^(OUT_W-1) for negative.
  - MODE 1: magnitude clamps to all ones, with the sign kept.
- Not defined: out-of-range results wrap, keeping the low OUT_W bits of the MODE 0 two's-complement value or the low OUT_W-1 magnitude bits in MODE 1.
- o_ovf is asserted identically in both builds.

Test Plan (IN_W=8, OUT_W=8, DEPTH=4, MODE=0 unless stated):
- Basic sign: i_val=5, signA=1, signB=0, i_stop pulse, i_ready=1 -> next cycle o_valid=1, o_product=0xFB, o_sign=1, o_ovf=0; o_valid=0 the following cycle.
- Boundaries:
  - i_val=128 negative -> 0x80, ovf=0.
  - i_val=0, signs 1/0 -> 0x00, o_sign=0.
  - i_val=200 positive -> ovf=1, o_product=0x7F with SAT_EN, 0xC8 without.
- MODE=1: i_val=5 negative -> 0x85. i_val=130 -> ovf=1, o_product=0xFF with SAT_EN (0x82 without).
- Backpressure: i_ready=0, five i_stop pulses with values 1..5 -> o_count=4, o_full=1, o_drop=1. Then i_ready=1 pops 1,2,3,4 in order and o_drop stays 1 until an i_start pulse.
- Full push+pop: FIFO full, i_stop with i_val=9 and i_ready=1 in the same cycle -> count stays 4, head advances, 9 is emitted last, o_drop unchanged.
- Reset/clear:
  - i_rst low mid-stream with 3 entries -> outputs 0 immediately, count 0.
  - Separately, i_clear coincident with i_stop -> count 0 next cycle and no entry pushed.

Source files
------------

// File: rtl/comp2_result_fifo.sv
// comp2_result_fifo: signs and range-checks multiplier magnitudes, then queues them for a valid/ready consumer.
// Optional build macro: COMP2_RESULT_SAT_EN (clamp out-of-range results instead of wrapping).
// Contains the generic show-ahead FIFO (comp2_gen_fifo) used for result storage.

// Generic show-ahead FIFO with synchronous flush.
// Latency: a push at edge t is visible at o_dat in cycle t+1; no bypass.
// Backpressure: caller must qualify i_push/i_pop; flush overrides both.
module comp2_gen_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_dat,
  output logic [W-1:0]               o_dat,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  logic [W-1:0]    r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;

  // Storage array: written only on an accepted push; contents are don't-care when empty.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (i_push && !i_pop)      r_count <= r_count + CNTW'(1);
      else if (!i_push && i_pop) r_count <= r_count - CNTW'(1);
    end
  end

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNTW'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

// Result formatter + FIFO: applies sign and format to i_val on i_stop and queues {ovf, sign, product}.
// Latency: one cycle from i_stop to o_valid when empty; older entries drain first, in order.
// Backpressure: i_ready=0 holds the head stable; a push into a full FIFO without a pop is dropped and flagged in sticky o_drop.
module comp2_result_fifo #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int DEPTH = 4,
  parameter int MODE  = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [IN_W-1:0]            i_val,
  input  logic                       i_signA,
  input  logic                       i_signB,
  input  logic                       i_stop,
  input  logic                       i_start,
  input  logic                       i_clear,
  input  logic                       i_ready,
  output logic [OUT_W-1:0]           o_product,
  output logic                       o_sign,
  output logic                       o_ovf,
  output logic                       o_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_drop
);
  // One guard bit above the wider of the two widths keeps the negation and limit compares exact.
  localparam int CW   = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;
  localparam int EW   = OUT_W + 2;
  localparam int CNTW = $clog2(DEPTH+1);

  logic [CW-1:0]    w_mag;
  logic [CW-1:0]    w_lim;
  logic [CW-1:0]    w_twos;
  logic             w_neg;
  logic             w_ovf;
  logic [OUT_W-1:0] w_res;
  logic [EW-1:0]    w_in_dat;
  logic [EW-1:0]    w_head;
  logic [CNTW-1:0]  w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_drop_ev;
  logic             r_drop;

  // Format the incoming magnitude: sign (with negative zero suppressed), range check, wrap or clamp.
  always_comb begin
    w_mag  = CW'(i_val);
    w_lim  = CW'(1) << (OUT_W-1);
    w_neg  = (i_signA ^ i_signB) && (i_val != '0);
    w_twos = w_neg ? (~w_mag + CW'(1)) : w_mag;
    w_ovf  = 1'b0;
    w_res  = '0;
    if (MODE == 0) begin
      // Negative side reaches one further than positive in two's complement.
      w_ovf = w_neg ? (w_mag > w_lim) : (w_mag >= w_lim);
      w_res = w_twos[OUT_W-1:0];
`ifdef COMP2_RESULT_SAT_EN
      if (w_ovf) w_res = w_neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
`endif
    end else begin
      w_ovf = (w_mag >= w_lim);
      w_res = {w_neg, w_mag[OUT_W-2:0]};
`ifdef COMP2_RESULT_SAT_EN
      if (w_ovf) w_res = {w_neg, {(OUT_W-1){1'b1}}};
`endif
    end
  end

  assign w_in_dat  = {w_ovf, w_neg, w_res};
  assign w_valid   = !w_empty;
  assign w_pop     = w_valid && i_ready;
  assign w_push    = i_stop && (!w_full || w_pop);
  assign w_drop_ev = i_stop && w_full && !w_pop;

  comp2_gen_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (w_in_dat),
    .o_dat   (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sticky drop flag: flush clears it, a lost push sets it and beats a same-cycle i_start.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_drop <= 1'b0;
    end else if (i_clear) begin
      r_drop <= 1'b0;
    end else if (w_drop_ev) begin
      r_drop <= 1'b1;
    end else if (i_start) begin
      r_drop <= 1'b0;
    end
  end

  // Head fields are forced to zero while empty so stale storage never leaks out.
  assign o_product = w_valid ? w_head[OUT_W-1:0] : '0;
  assign o_sign    = w_valid ? w_head[OUT_W]     : 1'b0;
  assign o_ovf     = w_valid ? w_head[OUT_W+1]   : 1'b0;
  assign o_valid   = w_valid;
  assign o_count   = w_count;
  assign o_full    = w_full;
  assign o_drop    = r_drop;
endmodule

// File: tb/tb_comp2_result_fifo.sv
// Testbench for comp2_result_fifo: a MODE 0 and a MODE 1 instance share one stimulus stream
// and are compared every cycle against a queue-based reference model.
module tb_comp2_result_fifo;
  logic       i_clk;
  logic       i_rst;
  logic [7:0] i_val;
  logic       i_signA, i_signB, i_stop, i_start, i_clear, i_ready;

  logic [7:0] o0_product, o1_product;
  logic       o0_sign, o0_ovf, o0_valid, o0_full, o0_drop;
  logic       o1_sign, o1_ovf, o1_valid, o1_full, o1_drop;
  logic [2:0] o0_count, o1_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: raw {signA, signB, val} per entry, plus the drop flag.
  logic [9:0] q[$];
  bit         m_drop;

  comp2_result_fifo #(.IN_W(8), .OUT_W(8), .DEPTH(4), .MODE(0)) u_dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_val(i_val), .i_signA(i_signA), .i_signB(i_signB),
    .i_stop(i_stop), .i_start(i_start), .i_clear(i_clear), .i_ready(i_ready),
    .o_product(o0_product), .o_sign(o0_sign), .o_ovf(o0_ovf), .o_valid(o0_valid),
    .o_count(o0_count), .o_full(o0_full), .o_drop(o0_drop)
  );

  comp2_result_fifo #(.IN_W(8), .OUT_W(8), .DEPTH(4), .MODE(1)) u_dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_val(i_val), .i_signA(i_signA), .i_signB(i_signB),
    .i_stop(i_stop), .i_start(i_start), .i_clear(i_clear), .i_ready(i_ready),
    .o_product(o1_product), .o_sign(o1_sign), .o_ovf(o1_ovf), .o_valid(o1_valid),
    .o_count(o1_count), .o_full(o1_full), .o_drop(o1_drop)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Expected {ovf, sign, product} for an 8-bit output, computed with signed integer arithmetic.
  function automatic logic [9:0] fmt(input int mode, input logic [9:0] e);
    int          v;
    int          s;
    bit          neg;
    bit          ovf;
    logic [31:0] t;
    v   = int'(e[7:0]);
    neg = (e[9] ^ e[8]) && (v != 0);
    s   = neg ? -v : v;
    if (mode == 0) begin
      ovf = (s > 127) || (s < -128);
      t   = s;
`ifdef COMP2_RESULT_SAT_EN
      if (ovf) t = neg ? 32'h80 : 32'h7F;
`endif
    end else begin
      ovf = (v > 127);
      t   = (neg ? 128 : 0) + (v % 128);
`ifdef COMP2_RESULT_SAT_EN
      if (ovf) t = (neg ? 128 : 0) + 127;
`endif
    end
    return {ovf, neg, t[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int m, input logic [7:0] prod, input logic sgn, input logic ovf,
                            input logic vld, input logic [2:0] cnt, input logic full, input logic drop);
    logic [9:0] e;
    e = (q.size() != 0) ? fmt(m, q[0]) : 10'h0;
    chk($sformatf("m%0d valid", m),   {31'h0, vld},  {31'h0, q.size() != 0});
    chk($sformatf("m%0d count", m),   {29'h0, cnt},  q.size());
    chk($sformatf("m%0d full", m),    {31'h0, full}, {31'h0, q.size() == 4});
    chk($sformatf("m%0d drop", m),    {31'h0, drop}, {31'h0, m_drop});
    chk($sformatf("m%0d product", m), {24'h0, prod}, {24'h0, e[7:0]});
    chk($sformatf("m%0d sign", m),    {31'h0, sgn},  {31'h0, e[8]});
    chk($sformatf("m%0d ovf", m),     {31'h0, ovf},  {31'h0, e[9]});
  endtask

  task automatic check_all();
    check_inst(0, o0_product, o0_sign, o0_ovf, o0_valid, o0_count, o0_full, o0_drop);
    check_inst(1, o1_product, o1_sign, o1_ovf, o1_valid, o1_count, o1_full, o1_drop);
  endtask

  // Drive one cycle of inputs (at a falling edge), advance the model, then check after the rising edge.
  task automatic tick(input bit stop, input logic [7:0] v, input bit sa, input bit sb,
                      input bit start, input bit clr, input bit rdy);
    bit pop, push, full;
    i_stop = stop; i_val = v; i_signA = sa; i_signB = sb;
    i_start = start; i_clear = clr; i_ready = rdy;
    if (clr) begin
      q.delete();
      m_drop = 1'b0;
    end else begin
      full = (q.size() == 4);
      pop  = (q.size() != 0) && rdy;
      push = stop && (!full || pop);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({sa, sb, v});
      if (stop && full && !pop) m_drop = 1'b1;
      else if (start)           m_drop = 1'b0;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    check_all();
  endtask

  task automatic idle(input bit rdy);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    i_rst = 1'b0; i_val = '0; i_signA = 0; i_signB = 0;
    i_stop = 0; i_start = 0; i_clear = 0; i_ready = 0;
    m_drop = 1'b0;
    #1;
    check_all();
    @(negedge i_clk);
    i_rst = 1'b1;
    idle(1'b0);

    // Basic sign: 5 * negative -> 0xFB, gone the cycle after.
    tick(1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("basic product", {24'h0, o0_product}, 32'hFB);
    chk("basic sign", {31'h0, o0_sign}, 32'h1);
    chk("mode1 neg5", {24'h0, o1_product}, 32'h85);
    idle(1'b1);
    chk("basic drained", {31'h0, o0_valid}, 32'h0);

    // Boundaries, chained with i_ready=1 so each push pops the previous head.
    tick(1'b1, 8'd128, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("neg128 product", {24'h0, o0_product}, 32'h80);
    chk("neg128 ovf", {31'h0, o0_ovf}, 32'h0);
    tick(1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("negzero product", {24'h0, o0_product}, 32'h00);
    chk("negzero sign", {31'h0, o0_sign}, 32'h0);
    tick(1'b1, 8'd200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pos200 ovf", {31'h0, o0_ovf}, 32'h1);
`ifdef COMP2_RESULT_SAT_EN
    chk("pos200 product", {24'h0, o0_product}, 32'h7F);
`else
    chk("pos200 product", {24'h0, o0_product}, 32'hC8);
`endif
    tick(1'b1, 8'd130, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mode1 130 ovf", {31'h0, o1_ovf}, 32'h1);
`ifdef COMP2_RESULT_SAT_EN
    chk("mode1 130 product", {24'h0, o1_product}, 32'hFF);
`else
    chk("mode1 130 product", {24'h0, o1_product}, 32'h82);
`endif
    idle(1'b1);

    // Backpressure: five pushes into a 4-deep FIFO, then ordered drain, drop sticky until i_start.
    for (int k = 1; k <= 5; k++) tick(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp count", {29'h0, o0_count}, 32'd4);
    chk("bp full", {31'h0, o0_full}, 32'h1);
    chk("bp drop", {31'h0, o0_drop}, 32'h1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("bp order %0d", k), {24'h0, o0_product}, k);
      idle(1'b1);
    end
    chk("bp drop sticky", {31'h0, o0_drop}, 32'h1);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("bp drop cleared", {31'h0, o0_drop}, 32'h0);

    // Full + push + pop: count holds, 9 emerges last, drop untouched.
    for (int k = 1; k <= 4; k++) tick(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fpp count", {29'h0, o0_count}, 32'd4);
    chk("fpp head", {24'h0, o0_product}, 32'd2);
    chk("fpp drop", {31'h0, o0_drop}, 32'h0);
    for (int k = 0; k < 3; k++) idle(1'b1);
    chk("fpp last", {24'h0, o0_product}, 32'd9);
    idle(1'b1);

    // Clear coincident with a push: nothing enters.
    tick(1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clear count", {29'h0, o0_count}, 32'd0);
    chk("clear valid", {31'h0, o0_valid}, 32'h0);

    // Asynchronous reset mid-stream with three entries held.
    for (int k = 0; k < 3; k++) tick(1'b1, 8'(40 + k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    i_stop = 0; i_ready = 0;
    #2;
    i_rst = 1'b0;
    #1;
    q.delete();
    m_drop = 1'b0;
    chk("arst count", {29'h0, o0_count}, 32'd0);
    chk("arst valid", {31'h0, o0_valid}, 32'h0);
    check_all();
    @(negedge i_clk);
    i_rst = 1'b1;
    check_all();

    // Randomised traffic with boundary-biased magnitudes.
    for (int n = 0; n < 600; n++) begin
      logic [7:0] v;
      case ($urandom_range(0, 5))
        0:       v = 8'd0;
        1:       v = 8'd127;
        2:       v = 8'd128;
        3:       v = 8'd129;
        default: v = 8'($urandom_range(0, 255));
      endcase
      tick(1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
